// File: rtl/cavlc_pkg.sv
// Shared definitions for the CAVLC coefficient rebuild block: zigzag scan table,
// controller states and the packed 4x4 coefficient block type.
package cavlc_pkg;

  localparam int COEF_W_DEF = 8;

  // Zigzag scan position -> raster index (row*4+col).
  localparam logic [3:0] ZIGZAG [16] = '{
    4'd0, 4'd1, 4'd4, 4'd8, 4'd5, 4'd2, 4'd3, 4'd6,
    4'd9, 4'd12, 4'd13, 4'd10, 4'd7, 4'd11, 4'd14, 4'd15
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEVEL = 2'd1,
    PLACE = 2'd2,
    OUT   = 2'd3
  } state_t;

  typedef logic [16*COEF_W_DEF-1:0] coef_blk_t;

  function automatic logic [3:0] zz_raster(input logic [3:0] pos);
    return ZIGZAG[pos];
  endfunction

endpackage

// File: rtl/cavlc_coef_buf.sv
// 16-entry coefficient register file written by zigzag position, read out in
// raster order as one packed block.
module cavlc_coef_buf
  import cavlc_pkg::*;
#(
  parameter int W = COEF_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_we,
  input  logic [3:0]    i_pos,
  input  logic [W-1:0]  i_data,
  output logic [16*W-1:0] o_coef
);

  logic [W-1:0] r_mem [16];
  logic [3:0]   w_addr;

  assign w_addr = zz_raster(i_pos);

  // Coefficient storage: clear wins over write so a new block always starts at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) r_mem[k] <= '0;
    end else if (i_clr) begin
      for (int k = 0; k < 16; k++) r_mem[k] <= '0;
    end else if (i_we) begin
      r_mem[w_addr] <= i_data;
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_out
    assign o_coef[g*W +: W] = r_mem[g];
  end

endmodule

// File: rtl/cavlc_coef_rebuild.sv
// CAVLC decoder-side coefficient rebuild: header + level + run_before streams in,
// raster-ordered 4x4 block out. Optional input checking: CAVLC_COEF_REBUILD_CHECK_EN.
module cavlc_coef_rebuild
  import cavlc_pkg::*;
#(
  parameter int COEF_W = COEF_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hdr_valid,
  output logic               hdr_ready,
  input  logic [4:0]         total_coeff_i,
  input  logic [1:0]         trailing_ones_i,
  input  logic [3:0]         total_zeros_i,
  input  logic               lvl_valid,
  output logic               lvl_ready,
  input  logic [COEF_W-1:0]  lvl_i,
  input  logic               run_valid,
  output logic               run_ready,
  input  logic [3:0]         run_i,
  output logic               blk_valid,
  input  logic               blk_ready,
  output logic [16*COEF_W-1:0] coef_o,
  output logic               err_o
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [4:0]         r_tc;
  logic [3:0]         r_tz;
  logic [3:0]         r_zl;
  logic [3:0]         r_cnt;
  logic [3:0]         r_idx;
  logic signed [4:0]  r_pos;
  logic [COEF_W-1:0]  r_lbuf [16];

  logic [4:0]         w_tc_hdr;
  logic [4:0]         w_tc_m1;
  logic [5:0]         w_pos_sum;
  logic signed [4:0]  w_pos_start;
  logic signed [5:0]  w_pos_dec;
  logic signed [4:0]  w_pos_nxt;
  logic [3:0]         w_run_amt;
  logic [3:0]         w_zl_dec;
  logic               w_need_run;
  logic               w_advance;
  logic               w_lvl_last;
  logic               w_idx_last;
  logic               w_hdr_fire;
  logic               w_lvl_fire;
  logic               w_run_fire;
  logic               w_we;

  // Datapath arithmetic: header clamp, start position and clamped position/zero updates.
  always_comb begin
    w_tc_hdr    = (total_coeff_i > 5'd16) ? 5'd16 : total_coeff_i;
    w_tc_m1     = r_tc - 5'd1;
    w_pos_sum   = {1'b0, r_tc} + {2'b00, r_tz} - 6'd1;
    w_pos_start = (w_pos_sum > 6'd15) ? 5'sd15 : $signed(w_pos_sum[4:0]);
    w_need_run  = ({1'b0, r_idx} < w_tc_m1) && (r_zl != 4'd0);
    w_run_amt   = w_need_run ? run_i : 4'd0;
    w_pos_dec   = $signed({r_pos[4], r_pos}) - 6'sd1 - $signed({2'b00, w_run_amt});
    w_pos_nxt   = w_pos_dec[5] ? 5'sd0 : w_pos_dec[4:0];
    w_zl_dec    = (run_i > r_zl) ? 4'd0 : (r_zl - run_i);
    w_advance   = w_need_run ? run_valid : 1'b1;
    w_lvl_last  = ({1'b0, r_cnt} == w_tc_m1);
    w_idx_last  = ({1'b0, r_idx} == w_tc_m1);
  end

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    hdr_ready   = 1'b0;
    lvl_ready   = 1'b0;
    run_ready   = 1'b0;
    blk_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        hdr_ready = 1'b1;
        if (hdr_valid) begin
          w_state_nxt = (total_coeff_i == 5'd0) ? OUT : LEVEL;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      LEVEL: begin
        lvl_ready = 1'b1;
        if (lvl_valid && w_lvl_last) begin
          w_state_nxt = PLACE;
        end else begin
          w_state_nxt = LEVEL;
        end
      end
      PLACE: begin
        run_ready = w_need_run;
        if (w_advance && w_idx_last) begin
          w_state_nxt = OUT;
        end else begin
          w_state_nxt = PLACE;
        end
      end
      OUT: begin
        blk_valid = 1'b1;
        if (blk_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = OUT;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_hdr_fire = (r_state == IDLE)  && hdr_valid;
  assign w_lvl_fire = (r_state == LEVEL) && lvl_valid;
  assign w_run_fire = (r_state == PLACE) && w_need_run && run_valid;
  assign w_we       = (r_state == PLACE) && w_advance;

  // Header latch, level capture and placement bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tc  <= 5'd0;
      r_tz  <= 4'd0;
      r_zl  <= 4'd0;
      r_cnt <= 4'd0;
      r_idx <= 4'd0;
      r_pos <= 5'sd0;
      for (int k = 0; k < 16; k++) r_lbuf[k] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hdr_fire) begin
            r_tc  <= w_tc_hdr;
            r_tz  <= total_zeros_i;
            r_zl  <= total_zeros_i;
            r_cnt <= 4'd0;
          end
        end
        LEVEL: begin
          if (w_lvl_fire) begin
            r_lbuf[r_cnt] <= lvl_i;
            r_cnt         <= r_cnt + 4'd1;
            if (w_lvl_last) begin
              r_idx <= 4'd0;
              r_pos <= w_pos_start;
            end
          end
        end
        PLACE: begin
          if (w_advance) begin
            r_pos <= w_pos_nxt;
            r_idx <= r_idx + 4'd1;
            if (w_need_run) r_zl <= w_zl_dec;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  cavlc_coef_buf #(.W(COEF_W)) u_buf (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_hdr_fire),
    .i_we   (w_we),
    .i_pos  (r_pos[3:0]),
    .i_data (r_lbuf[r_idx]),
    .o_coef (coef_o)
  );

`ifdef CAVLC_COEF_REBUILD_CHECK_EN
  logic [1:0] r_t1;
  logic       r_err;
  logic [5:0] w_hdr_sum;
  logic [1:0] w_t1_max;
  logic       w_hdr_err;
  logic       w_lvl_err;
  logic       w_run_err;

  // Syntax-element legality checks; the datapath keeps running with clamping.
  always_comb begin
    w_hdr_sum = {1'b0, total_coeff_i} + {2'b00, total_zeros_i};
    w_t1_max  = (total_coeff_i > 5'd3) ? 2'd3 : total_coeff_i[1:0];
    w_hdr_err = (total_coeff_i > 5'd16) || (w_hdr_sum > 6'd16) || (trailing_ones_i > w_t1_max);
    w_lvl_err = (r_cnt < {2'b00, r_t1}) &&
                (lvl_i != {{(COEF_W-1){1'b0}}, 1'b1}) &&
                (lvl_i != {COEF_W{1'b1}});
    w_run_err = (run_i > r_zl);
  end

  // Sticky error: restarted by each accepted header.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
      r_t1  <= 2'd0;
    end else if (w_hdr_fire) begin
      r_err <= w_hdr_err;
      r_t1  <= trailing_ones_i;
    end else if ((w_lvl_fire && w_lvl_err) || (w_run_fire && w_run_err)) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  logic w_unused_t1;
  assign w_unused_t1 = ^{trailing_ones_i, w_run_fire};
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cavlc_coef_rebuild.sv
// Scoreboard bench for cavlc_coef_rebuild: expected blocks are queued by the driver
// and compared when the DUT presents blk_valid.
module tb_cavlc_coef_rebuild;
  import cavlc_pkg::*;

  localparam int W = 8;

  typedef logic signed [W-1:0] lv_arr_t [16];
  typedef int rn_arr_t [16];
  typedef struct {
    logic [16*W-1:0] coef;
    logic            err;
  } exp_t;

  logic clk, rst;
  logic hdr_valid, hdr_ready;
  logic [4:0] total_coeff_i;
  logic [1:0] trailing_ones_i;
  logic [3:0] total_zeros_i;
  logic lvl_valid, lvl_ready;
  logic [W-1:0] lvl_i;
  logic run_valid, run_ready;
  logic [3:0] run_i;
  logic blk_valid, blk_ready;
  logic [16*W-1:0] coef_o;
  logic err_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int hdr_cyc = 0;
  int lvl_rdy_cyc = 0;
  int run_rdy_cyc = 0;
  int run_hs = 0;
  exp_t sb[$];

  localparam int ZZ [16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};

`ifdef CAVLC_COEF_REBUILD_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  cavlc_coef_rebuild #(.COEF_W(W)) dut (
    .clk(clk), .rst(rst),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .total_coeff_i(total_coeff_i), .trailing_ones_i(trailing_ones_i), .total_zeros_i(total_zeros_i),
    .lvl_valid(lvl_valid), .lvl_ready(lvl_ready), .lvl_i(lvl_i),
    .run_valid(run_valid), .run_ready(run_ready), .run_i(run_i),
    .blk_valid(blk_valid), .blk_ready(blk_ready),
    .coef_o(coef_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (lvl_ready) lvl_rdy_cyc <= lvl_rdy_cyc + 1;
    if (run_ready) run_rdy_cyc <= run_rdy_cyc + 1;
    if (run_ready && run_valid) run_hs <= run_hs + 1;
  end

  function automatic logic [16*W-1:0] model(input int tc, input int tz, input lv_arr_t lv,
                                             input rn_arr_t rn, output int nruns);
    logic [16*W-1:0] blk = '0;
    int pos = tc + tz - 1;
    int zl = tz;
    nruns = 0;
    if (pos > 15) pos = 15;
    for (int i = 0; i < tc; i++) begin
      blk[ZZ[pos]*W +: W] = lv[i];
      if (i < tc - 1 && zl > 0) begin
        int r = rn[nruns];
        nruns++;
        pos = pos - 1 - r;
        zl = (r > zl) ? 0 : zl - r;
      end else begin
        pos = pos - 1;
      end
      if (pos < 0) pos = 0;
    end
    return blk;
  endfunction

  task automatic gap(input bit en);
    if (en) repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic send_hdr(input int tc, input int t1, input int tz, input bit gaps);
    int n = 0;
    gap(gaps);
    @(negedge clk);
    hdr_valid = 1'b1;
    total_coeff_i = 5'(tc);
    trailing_ones_i = 2'(t1);
    total_zeros_i = 4'(tz);
    while (!hdr_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      n_tests++; n_fail++;
      $display("FAIL hdr_timeout: hdr_ready=%0b required 1", hdr_ready);
    end
    @(posedge clk); #1;
    hdr_valid = 1'b0;
    hdr_cyc = cyc;
  endtask

  task automatic send_lvl(input logic signed [W-1:0] v, input bit gaps);
    int n = 0;
    gap(gaps);
    @(negedge clk);
    lvl_valid = 1'b1;
    lvl_i = v;
    while (!lvl_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      n_tests++; n_fail++;
      $display("FAIL lvl_timeout: lvl_ready=%0b required 1", lvl_ready);
    end
    @(posedge clk); #1;
    lvl_valid = 1'b0;
  endtask

  task automatic send_run(input int r, input bit gaps);
    int n = 0;
    gap(gaps);
    @(negedge clk);
    run_valid = 1'b1;
    run_i = 4'(r);
    while (!run_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      n_tests++; n_fail++;
      $display("FAIL run_timeout: run_ready=%0b required 1", run_ready);
    end
    @(posedge clk); #1;
    run_valid = 1'b0;
  endtask

  task automatic collect(input string name, input int bp, input int exp_lat);
    int n = 0;
    exp_t e;
    logic [16*W-1:0] snap;
    bit bad = 1'b0;
    @(negedge clk);
    while (!blk_valid && n < 200) begin @(negedge clk); n++; end
    n_tests++;
    if (!blk_valid) begin
      n_fail++;
      $display("FAIL %s_blk_timeout: blk_valid=%0b required 1", name, blk_valid);
      return;
    end
    if (exp_lat >= 0) begin
      n_tests++;
      if (cyc - hdr_cyc !== exp_lat) begin
        n_fail++;
        $display("FAIL %s_latency: got %0d required %0d", name, cyc - hdr_cyc, exp_lat);
      end
    end
    e = sb.pop_front();
    n_tests++;
    if (coef_o !== e.coef) begin
      n_fail++;
      $display("FAIL %s_coef: got %h required %h", name, coef_o, e.coef);
    end
    n_tests++;
    if (err_o !== e.err) begin
      n_fail++;
      $display("FAIL %s_err: got %0b required %0b", name, err_o, e.err);
    end
    if (bp > 0) begin
      snap = coef_o;
      repeat (bp) begin
        @(negedge clk);
        if (coef_o !== snap || hdr_ready !== 1'b0 || blk_valid !== 1'b1) bad = 1'b1;
      end
      n_tests++;
      if (bad) begin
        n_fail++;
        $display("FAIL %s_hold: coef=%h hdr_ready=%0b blk_valid=%0b required stable,0,1",
                 name, coef_o, hdr_ready, blk_valid);
      end
    end
    blk_ready = 1'b1;
    @(posedge clk); #1;
    blk_ready = 1'b0;
    n_tests++;
    if (hdr_ready !== 1'b1 || blk_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_release: hdr_ready=%0b blk_valid=%0b required 1,0", name, hdr_ready, blk_valid);
    end
  endtask

  task automatic run_block(input string name, input int tc, input int t1, input int tz,
                           input lv_arr_t lv, input rn_arr_t rn, input bit gaps,
                           input int bp, input logic exp_err, input int exp_lat);
    exp_t e;
    int nr;
    e.coef = model(tc, tz, lv, rn, nr);
    e.err = exp_err;
    sb.push_back(e);
    send_hdr(tc, t1, tz, gaps);
    for (int i = 0; i < tc; i++) send_lvl(lv[i], gaps);
    for (int i = 0; i < nr; i++) send_run(rn[i], gaps);
    collect(name, bp, exp_lat);
  endtask

  function automatic logic [16*W-1:0] pack(input lv_arr_t r);
    logic [16*W-1:0] b;
    for (int k = 0; k < 16; k++) b[k*W +: W] = r[k];
    return b;
  endfunction

  lv_arr_t lv1 = '{-8'sd1, 8'sd1, -8'sd1, -8'sd1, -8'sd1, 8'sd1, -8'sd1, 8'sd2,
                   8'sd1, -8'sd1, -8'sd2, 8'sd2, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
  lv_arr_t rs1 = '{8'sd2, -8'sd2, -8'sd1, 8'sd1, -8'sd1, 8'sd2, -8'sd1, -8'sd1,
                   8'sd1, -8'sd1, 8'sd0, 8'sd0, -8'sd1, 8'sd1, 8'sd0, 8'sd0};
  rn_arr_t rn1 = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  task automatic test_reset();
    rst = 1'b1;
    hdr_valid = 1'b0; lvl_valid = 1'b0; run_valid = 1'b0; blk_ready = 1'b0;
    total_coeff_i = 5'd0; trailing_ones_i = 2'd0; total_zeros_i = 4'd0;
    lvl_i = '0; run_i = 4'd0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (hdr_ready !== 1'b1 || lvl_ready !== 1'b0 || run_ready !== 1'b0 ||
        blk_valid !== 1'b0 || coef_o !== '0 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: hr=%0b lr=%0b rr=%0b bv=%0b coef=%h err=%0b required 1,0,0,0,0,0",
               hdr_ready, lvl_ready, run_ready, blk_valid, coef_o, err_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_spec_block();
    int hs0 = run_hs;
    run_block("tc12", 12, 3, 1, lv1, rn1, 1'b0, 0, 1'b0, 24);
    n_tests++;
    if (coef_o !== pack(rs1)) begin
      n_fail++;
      $display("FAIL tc12_raster: got %h required %h", coef_o, pack(rs1));
    end
    n_tests++;
    if (run_hs - hs0 !== 1) begin
      n_fail++;
      $display("FAIL tc12_runs: got %0d required 1", run_hs - hs0);
    end
  endtask

  task automatic test_zero_block();
    lv_arr_t lv = '{default: 8'sd0};
    rn_arr_t rn = '{default: 0};
    int l0 = lvl_rdy_cyc;
    int r0 = run_rdy_cyc;
    run_block("tc0", 0, 0, 0, lv, rn, 1'b0, 0, 1'b0, 0);
    n_tests++;
    if (coef_o !== '0) begin
      n_fail++;
      $display("FAIL tc0_zero: got %h required 0", coef_o);
    end
    n_tests++;
    if (lvl_rdy_cyc !== l0 || run_rdy_cyc !== r0) begin
      n_fail++;
      $display("FAIL tc0_ready: lvl_ready cycles %0d run_ready cycles %0d required 0,0",
               lvl_rdy_cyc - l0, run_rdy_cyc - r0);
    end
  endtask

  task automatic test_full_block();
    lv_arr_t lv;
    rn_arr_t rn = '{default: 0};
    int r0 = run_rdy_cyc;
    for (int i = 0; i < 16; i++) lv[i] = 8'(16 - i);
    run_block("tc16", 16, 0, 0, lv, rn, 1'b0, 0, 1'b0, 32);
    n_tests++;
    if (coef_o[0 +: W] !== 8'd1 || coef_o[15*W +: W] !== 8'd16) begin
      n_fail++;
      $display("FAIL tc16_ends: raster0=%0d raster15=%0d required 1,16", coef_o[0 +: W], coef_o[15*W +: W]);
    end
    n_tests++;
    if (run_rdy_cyc !== r0) begin
      n_fail++;
      $display("FAIL tc16_runs: run_ready cycles %0d required 0", run_rdy_cyc - r0);
    end
  endtask

  task automatic test_run_block();
    lv_arr_t lv = '{default: 8'sd0};
    rn_arr_t rn = '{default: 0};
    lv_arr_t rs = '{default: 8'sd0};
    lv[0] = 8'sd5; lv[1] = -8'sd3; rn[0] = 3;
    rs[5] = 8'sd5; rs[0] = -8'sd3;
    run_block("tc2run", 2, 0, 3, lv, rn, 1'b0, 0, 1'b0, 4);
    n_tests++;
    if (coef_o !== pack(rs)) begin
      n_fail++;
      $display("FAIL tc2run_raster: got %h required %h", coef_o, pack(rs));
    end
  endtask

  task automatic test_backpressure();
    run_block("bp", 12, 3, 1, lv1, rn1, 1'b0, 10, 1'b0, 24);
    run_block("gaps", 12, 3, 1, lv1, rn1, 1'b1, 3, 1'b0, -1);
    n_tests++;
    if (coef_o !== pack(rs1)) begin
      n_fail++;
      $display("FAIL gaps_raster: got %h required %h", coef_o, pack(rs1));
    end
  endtask

  task automatic test_back_to_back();
    lv_arr_t lv;
    rn_arr_t rn = '{default: 0};
    for (int b = 0; b < 3; b++) begin
      int tc = $urandom_range(1, 10);
      int tz = $urandom_range(0, 16 - tc);
      int left = tz;
      for (int i = 0; i < 16; i++) lv[i] = 8'($urandom_range(1, 100));
      for (int i = 0; i < 16; i++) begin
        rn[i] = $urandom_range(0, left);
        left = left - rn[i];
      end
      run_block("b2b", tc, 0, tz, lv, rn, 1'b0, 0, 1'b0, -1);
    end
  endtask

  task automatic test_check();
    lv_arr_t lv = '{default: 8'sd0};
    rn_arr_t rn = '{default: 0};
    lv[0] = 8'sd4; lv[1] = 8'sd7; rn[0] = 3;
    run_block("chk_run", 2, 0, 1, lv, rn, 1'b0, 0, CHK, -1);
    lv[0] = 8'sd3; lv[1] = 8'sd1;
    run_block("chk_t1", 2, 2, 0, lv, rn, 1'b0, 0, CHK, -1);
    lv[0] = -8'sd1; lv[1] = 8'sd9;
    run_block("chk_clear", 2, 1, 0, lv, rn, 1'b0, 0, 1'b0, -1);
  endtask

  task automatic test_reset_mid_level();
    lv_arr_t lv = '{default: 8'sd0};
    rn_arr_t rn = '{default: 0};
    send_hdr(5, 0, 2, 1'b0);
    send_lvl(8'sd11, 1'b0);
    send_lvl(8'sd12, 1'b0);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (hdr_ready !== 1'b1 || lvl_ready !== 1'b0 || run_ready !== 1'b0 ||
        blk_valid !== 1'b0 || coef_o !== '0 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_state: hr=%0b lr=%0b rr=%0b bv=%0b coef=%h err=%0b required 1,0,0,0,0,0",
               hdr_ready, lvl_ready, run_ready, blk_valid, coef_o, err_o);
    end
    @(negedge clk);
    rst = 1'b0;
    lv[0] = 8'sd6; lv[1] = -8'sd4; lv[2] = 8'sd2;
    rn[0] = 1; rn[1] = 1;
    run_block("post_rst", 3, 0, 2, lv, rn, 1'b0, 0, 1'b0, 6);
    n_tests++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_left: got %0d entries required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_spec_block();
    test_zero_block();
    test_full_block();
    test_run_block();
    test_backpressure();
    test_back_to_back();
    test_check();
    test_reset_mid_level();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cavlc_coef_rebuild.md
Name: cavlc_coef_rebuild

Overview:
- Decoder-side counterpart of the CAVLC encoder's coefficient-analysis stage.
- Inputs are already-parsed CAVLC syntax elements for one 4x4 block:
  - header: total_coeff, trailing_ones, total_zeros
  - level stream: nonzero values, highest frequency first
  - run_before stream
- Output is the reconstructed 4x4 block of signed 8-bit coefficients in raster order, for the inverse-quant/IDCT path and for encoder loopback checking.
- All three inputs and the output use valid/ready handshakes.

Parameters:
- COEF_W, 8, coefficient width in bits (two's complement).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- hdr_valid  in  1  header valid
- hdr_ready  out  1  header accepted when hdr_valid && hdr_ready
- total_coeff_i  in  5  nonzero count, 0..16
- trailing_ones_i  in  2  trailing ±1 count, 0..3 (informational; used by the check only)
- total_zeros_i  in  4  zeros before the last nonzero in zigzag order
- lvl_valid  in  1  level valid
- lvl_ready  out  1  level accepted on handshake
- lvl_i  in  COEF_W  signed level value
- run_valid  in  1  run_before valid
- run_ready  out  1  run accepted on handshake
- run_i  in  4  run_before value
- blk_valid  out  1  output block valid
- blk_ready  in  1  downstream ready
- coef_o  out  16xCOEF_W  packed; element k is raster index k (row*4+col)
- err_o  out  1  sticky error flag, cleared on header accept

Behaviour:
- Reset: state IDLE; hdr_ready=1; lvl_ready=0; run_ready=0; blk_valid=0; coef_o=0; err_o=0; level buffer and counters cleared. Reset mid-block discards the block; no partial output.
- IDLE state:
  - hdr_ready=1.
  - On header accept, latch tc, tz and zeros_left=tz, then clear the coef buffer.
  - If tc==0, go to OUT. Otherwise set cnt=0 and go to LEVEL.
- LEVEL state:
  - lvl_ready=1.
  - Each accept stores lvl_i to lbuf[cnt] and increments cnt.
  - The accept with cnt==tc-1 sets idx=0, pos=tc+tz-1, then goes to PLACE.
- PLACE state:
  - Each advance writes lbuf[idx] into coef buffer at raster ZIGZAG[pos].
  - need_run = (idx<tc-1) && (zeros_left>0). run_ready=need_run.
  - If need_run: advance only on run handshake; pos -= 1+run_i; zeros_left -= run_i.
  - Else: advance every cycle; pos -= 1; no run consumed.
  - After idx==tc-1, go to OUT. Zeros remaining below the last placed coefficient stay 0.
- OUT state:
  - blk_valid=1; coef_o is registered and stable while blk_valid=1.
  - On blk_ready, go to IDLE.
  - hdr_ready=0 in OUT, so a header offered on the same cycle as the output handshake is taken the following cycle.
- Latency:
  - tc=0: blk_valid in the cycle after header accept.
  - Otherwise: with streams back-to-back, blk_valid appears tc level cycles + tc place cycles after header accept.
- Width rules: pos is a 5-bit signed working value. Subtraction never underflows for legal input. For illegal input, clamp pos at 0 and zeros_left at 0.
- ZIGZAG scan, zigzag pos 0..15 → raster index: 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15.

Optional Feature:
- Macro: CAVLC_COEF_REBUILD_CHECK_EN
- When defined, err_o is set if any of these occur:
  - tc>16
  - tc+tz>16
  - trailing_ones_i>min(tc,3)
  - any of the first trailing_ones_i levels is not ±1
  - run_i>zeros_left
- When defined, processing continues with clamping regardless of err_o.
- When undefined, err_o is tied 0 and no check logic is built.

Decomposition:
- Shared package cavlc_pkg:
  - ZIGZAG constant array
  - state enum {IDLE, LEVEL, PLACE, OUT}
  - COEF_W default
  - coef block typedef
- One natural sub-module: cavlc_coef_buf.
  - 16-entry coefficient register file.
  - Single write port addressed by zigzag pos (LUT inside), plus synchronous clear.
  - Exposes all 16 entries to coef_o.

Test Plan:
- Header tc=12, t1=3, tz=1; levels -1,1,-1,-1,-1,1,-1,2,1,-1,-2,2; run 1 → exactly one run accepted; coef_o raster = 2,-2,-1,1,-1,2,-1,-1,1,-1,0,0,-1,1,0,0; err_o=0.
- Header tc=0, tz=0 → blk_valid the next cycle; all coef_o=0; lvl_ready and run_ready never asserted.
- Header tc=16, tz=0; levels 16..1 → raster follows ZIGZAG (zigzag pos 0 value 1, pos 15 value 16); no runs requested.
- Header tc=2, tz=3; levels 5,-3; run 3 → 5 at raster ZIGZAG[4]=5, -3 at raster 0, rest 0.
- Back-pressure: hold blk_ready=0 for 10 cycles → coef_o stable, hdr_ready=0; header accepted 1 cycle after blk_ready; random gaps on lvl_valid/run_valid give the same result.
- Check build: tc=2, tz=1, run 3 → err_o=1 and pos clamped. Assert rst mid-LEVEL → all outputs return to reset values immediately.
